// File: rtl/dma_arb_pkg.sv
// DMA channel arbiter shared types and limits.
// Exports: arb_state_t (ARB_IDLE/ARB_GRANT/ARB_RELEASE), MAX_CH.
package dma_arb_pkg;

   localparam int MAX_CH = 8;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT   = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// Request/grant bundle for the DMA channel arbiter.
// master: drives requests/config/timing; slave: drives dack/grant/release.
interface dma_channel_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH)
) ();

   logic [NUM_CH-1:0] dreq;
   logic [NUM_CH-1:0] sw_req;
   logic [NUM_CH-1:0] mask;
   logic              priority_type;
   logic              dreq_sense_low;
   logic              dack_sense_high;
   logic              grant_en;
   logic              xfer_done;
   logic [NUM_CH-1:0] dack;
   logic              grant_valid;
   logic [CH_W-1:0]   grant_ch;
   logic              release_pulse;

   modport master (
      output dreq, sw_req, mask,
      output priority_type, dreq_sense_low,
      output dack_sense_high, grant_en, xfer_done,
      input  dack, grant_valid, grant_ch,
      input  release_pulse
   );

   modport slave (
      input  dreq, sw_req, mask,
      input  priority_type, dreq_sense_low,
      input  dack_sense_high, grant_en, xfer_done,
      output dack, grant_valid, grant_ch,
      output release_pulse
   );

endinterface

// File: rtl/dma_rr_select.sv
// Combinational priority picker: first eligible channel from ptr upward.
// in: eligible, ptr; out: win_vec (one-hot), win_idx.
module dma_rr_select #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] eligible,
   input  logic [CH_W-1:0]   ptr,
   output logic [NUM_CH-1:0] win_vec,
   output logic [CH_W-1:0]   win_idx
);

   logic [CH_W:0]   sum;
   logic [CH_W-1:0] idx;

   // Scan from lowest priority to highest so the
   // last hit (closest to ptr) wins.
   always_comb begin
      win_vec = '0;
      win_idx = '0;
      sum     = '0;
      idx     = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (CH_W + 1)'(k);
         if (sum >= (CH_W + 1)'(NUM_CH))
            sum = sum - (CH_W + 1)'(NUM_CH);
         idx = sum[CH_W-1:0];
         if (eligible[idx]) begin
            win_vec      = '0;
            win_vec[idx] = 1'b1;
            win_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: fixed/rotating priority, grant held until done.
// in: CLK, RESET_N, requests, config, timing; out: DACK, GRANT_*, RELEASE_PULSE.
module dma_channel_arbiter
   import dma_arb_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [NUM_CH-1:0] DREQ,
   input  logic [NUM_CH-1:0] SW_REQ,
   input  logic [NUM_CH-1:0] MASK,
   input  logic              PRIORITY_TYPE,
   input  logic              DREQ_SENSE_LOW,
   input  logic              DACK_SENSE_HIGH,
   input  logic              GRANT_EN,
   input  logic              XFER_DONE,
   output logic [NUM_CH-1:0] DACK,
   output logic              GRANT_VALID,
   output logic [CH_W-1:0]   GRANT_CH,
   output logic              RELEASE_PULSE
);

   if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad
      $error("NUM_CH out of range");
   end

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] win_vec;
   logic [NUM_CH-1:0] gnt_vec;
   logic [CH_W-1:0]   win_idx;
   logic [CH_W-1:0]   gnt_idx;
   logic [CH_W-1:0]   ptr;
   logic [CH_W-1:0]   sel_ptr;
   logic              take;
   logic              done;

   assign eligible = ((DREQ ^ {NUM_CH{DREQ_SENSE_LOW}})
                     | SW_REQ) & ~MASK;

   // Fixed mode is rotating mode pinned at ptr 0.
   assign sel_ptr = PRIORITY_TYPE ? ptr : '0;

   dma_rr_select #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_sel (
      .eligible (eligible),
      .ptr      (sel_ptr),
      .win_vec  (win_vec),
      .win_idx  (win_idx)
   );

   assign take = (state == ARB_IDLE) && GRANT_EN
                 && (|eligible);
   assign done = (state == ARB_GRANT) && XFER_DONE;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= ARB_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE:    if (take) state_nxt = ARB_GRANT;
         ARB_GRANT:   if (done) state_nxt = ARB_RELEASE;
         ARB_RELEASE: state_nxt = ARB_IDLE;
         default:     state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         gnt_vec <= '0;
         gnt_idx <= '0;
         ptr     <= '0;
      end else begin
         if (take) begin
            gnt_vec <= win_vec;
            gnt_idx <= win_idx;
         end else if (done) begin
            gnt_vec <= '0;
         end
         if (!PRIORITY_TYPE)
            ptr <= '0;
         else if (done)
            ptr <= (gnt_idx == CH_W'(NUM_CH - 1))
                   ? '0 : gnt_idx + CH_W'(1);
      end
   end

   always_comb begin
      DACK          = DACK_SENSE_HIGH ? gnt_vec : ~gnt_vec;
      GRANT_VALID   = (state == ARB_GRANT);
      GRANT_CH      = gnt_idx;
      RELEASE_PULSE = (state == ARB_RELEASE);
   end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter (NUM_CH=4).
// Scoreboard of expected grant channels checked on each new grant.
module tb_dma_channel_arbiter;

   localparam int N = 4;
   localparam int W = 2;

   logic CLK = 1'b0;
   logic RESET_N = 1'b0;

   dma_channel_arbiter_if #(.NUM_CH(N), .CH_W(W)) bus ();

   dma_channel_arbiter #(.NUM_CH(N), .CH_W(W)) dut (
      .CLK             (CLK),
      .RESET_N         (RESET_N),
      .DREQ            (bus.dreq),
      .SW_REQ          (bus.sw_req),
      .MASK            (bus.mask),
      .PRIORITY_TYPE   (bus.priority_type),
      .DREQ_SENSE_LOW  (bus.dreq_sense_low),
      .DACK_SENSE_HIGH (bus.dack_sense_high),
      .GRANT_EN        (bus.grant_en),
      .XFER_DONE       (bus.xfer_done),
      .DACK            (bus.dack),
      .GRANT_VALID     (bus.grant_valid),
      .GRANT_CH        (bus.grant_ch),
      .RELEASE_PULSE   (bus.release_pulse)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   bit prev_gv = 1'b0;

   // Scoreboard: every rising GRANT_VALID must match the next
   // expected channel, both as index and as polarity-aware DACK.
   always @(negedge CLK) begin
      logic [N-1:0] oh;
      int e;
      if (RESET_N && bus.grant_valid === 1'b1 && !prev_gv) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got ch %0d want none",
                     bus.grant_ch);
         end else begin
            e = exp_q.pop_front();
            oh = '0;
            oh[e] = 1'b1;
            if (!bus.dack_sense_high) oh = ~oh;
            if (bus.grant_ch !== W'(e) || bus.dack !== oh) begin
               errors++;
               $display("FAIL sb_grant: got ch %0d dack %b want ch %0d dack %b",
                        bus.grant_ch, bus.dack, e, oh);
            end
         end
      end
      prev_gv = RESET_N && (bus.grant_valid === 1'b1);
   end

   task automatic wait_grant(output bit got);
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (bus.grant_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.dreq = 4'b0001;
      bus.grant_en = 1'b1;
      @(negedge CLK);
      checks++;
      if ({bus.dack, bus.grant_valid, bus.grant_ch,
           bus.release_pulse} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got %b%b%b%b want 0",
                  bus.dack, bus.grant_valid, bus.grant_ch,
                  bus.release_pulse);
      end
      RESET_N = 1'b1;
      exp_q.push_back(0);
      @(negedge CLK);
      checks++;
      if (bus.grant_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_grant: got %b want 1",
                  bus.grant_valid);
      end
      bus.dreq = '0;
      bus.xfer_done = 1'b1;
      @(negedge CLK);
      bus.xfer_done = 1'b0;
      checks++;
      if (bus.release_pulse !== 1'b1 || bus.dack !== 4'b0000) begin
         errors++;
         $display("FAIL release: got pulse %b dack %b want 1 0000",
                  bus.release_pulse, bus.dack);
      end
      @(negedge CLK);
      checks++;
      if (bus.release_pulse !== 1'b0) begin
         errors++;
         $display("FAIL pulse_width: got %b want 0",
                  bus.release_pulse);
      end
      bus.xfer_done = 1'b1;
      @(negedge CLK);
      bus.xfer_done = 1'b0;
      checks++;
      if (bus.release_pulse !== 1'b0 ||
          bus.grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL done_in_idle: got pulse %b gv %b want 0 0",
                  bus.release_pulse, bus.grant_valid);
      end
   endtask

   task automatic test_fixed();
      bus.dreq = 4'b1010;
      exp_q.push_back(1);
      @(negedge CLK);
      checks++;
      if (bus.dack !== 4'b0010 || bus.grant_ch !== 2'd1) begin
         errors++;
         $display("FAIL fixed_latency: got dack %b ch %0d want 0010 1",
                  bus.dack, bus.grant_ch);
      end
      bus.dreq = '0;
      bus.mask = 4'b0010;
      bus.sw_req = 4'b0001;
      repeat (3) @(negedge CLK);
      checks++;
      if (bus.dack !== 4'b0010 || bus.grant_valid !== 1'b1) begin
         errors++;
         $display("FAIL fixed_hold: got dack %b gv %b want 0010 1",
                  bus.dack, bus.grant_valid);
      end
      bus.mask = '0;
      bus.sw_req = '0;
      bus.xfer_done = 1'b1;
      @(negedge CLK);
      bus.xfer_done = 1'b0;
      checks++;
      if (bus.dack !== 4'b0000 || bus.release_pulse !== 1'b1) begin
         errors++;
         $display("FAIL fixed_release: got dack %b pulse %b want 0000 1",
                  bus.dack, bus.release_pulse);
      end
      @(negedge CLK);
   endtask

   task automatic test_mask();
      bus.mask = 4'b0001;
      bus.sw_req = 4'b0001;
      repeat (3) @(negedge CLK);
      checks++;
      if (bus.grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL masked: got gv %b want 0", bus.grant_valid);
      end
      bus.mask = '0;
      exp_q.push_back(0);
      @(negedge CLK);
      checks++;
      if (bus.dack !== 4'b0001) begin
         errors++;
         $display("FAIL unmasked: got dack %b want 0001", bus.dack);
      end
      bus.sw_req = '0;
      bus.xfer_done = 1'b1;
      @(negedge CLK);
      bus.xfer_done = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_polarity();
      bus.grant_en = 1'b0;
      bus.dreq = 4'b1011;
      bus.dreq_sense_low = 1'b1;
      bus.dack_sense_high = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if (bus.dack !== 4'b1111 || bus.grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL grant_en_block: got dack %b gv %b want 1111 0",
                  bus.dack, bus.grant_valid);
      end
      bus.grant_en = 1'b1;
      exp_q.push_back(2);
      @(negedge CLK);
      checks++;
      if (bus.dack !== 4'b1011) begin
         errors++;
         $display("FAIL active_low: got dack %b want 1011", bus.dack);
      end
      bus.dreq = 4'b1111;
      bus.xfer_done = 1'b1;
      @(negedge CLK);
      bus.xfer_done = 1'b0;
      checks++;
      if (bus.dack !== 4'b1111 || bus.release_pulse !== 1'b1) begin
         errors++;
         $display("FAIL low_release: got dack %b pulse %b want 1111 1",
                  bus.dack, bus.release_pulse);
      end
      @(negedge CLK);
      bus.dreq = '0;
      bus.dreq_sense_low = 1'b0;
      bus.dack_sense_high = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_rotating();
      int order[5] = '{0, 1, 2, 3, 0};
      bit got;
      bus.priority_type = 1'b1;
      bus.dreq = 4'b1111;
      foreach (order[i]) begin
         exp_q.push_back(order[i]);
         wait_grant(got);
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL rot_timeout: got no grant want ch %0d",
                     order[i]);
         end
         if (i == 4) bus.dreq = '0;
         bus.xfer_done = 1'b1;
         @(negedge CLK);
         bus.xfer_done = 1'b0;
      end
      @(negedge CLK);
   endtask

   task automatic test_reset_mid_grant();
      bit got;
      bus.dreq = 4'b0100;
      exp_q.push_back(2);
      wait_grant(got);
      checks++;
      if (!got || bus.dack !== 4'b0100) begin
         errors++;
         $display("FAIL mid_grant: got dack %b want 0100", bus.dack);
      end
      bus.dreq = 4'b1111;
      #2;
      RESET_N = 1'b0;
      #1;
      checks++;
      if (bus.dack !== 4'b0000 || bus.grant_valid !== 1'b0 ||
          bus.release_pulse !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got dack %b gv %b pulse %b want 0000 0 0",
                  bus.dack, bus.grant_valid, bus.release_pulse);
      end
      @(negedge CLK);
      checks++;
      if (bus.release_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_pulse: got %b want 0",
                  bus.release_pulse);
      end
      RESET_N = 1'b1;
      exp_q.push_back(0);
      wait_grant(got);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL post_reset: got no grant want ch 0");
      end
      bus.dreq = '0;
      bus.xfer_done = 1'b1;
      @(negedge CLK);
      bus.xfer_done = 1'b0;
      @(negedge CLK);
      bus.priority_type = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_back_to_back();
      bit got;
      bus.dreq = 4'b0011;
      exp_q.push_back(0);
      wait_grant(got);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL b2b_timeout: got no grant want ch 0");
      end
      exp_q.push_back(0);
      bus.xfer_done = 1'b1;
      @(negedge CLK);
      bus.xfer_done = 1'b0;
      checks++;
      if (bus.release_pulse !== 1'b1 || bus.dack !== 4'b0000) begin
         errors++;
         $display("FAIL b2b_gap1: got pulse %b dack %b want 1 0000",
                  bus.release_pulse, bus.dack);
      end
      @(negedge CLK);
      checks++;
      if (bus.release_pulse !== 1'b0 || bus.dack !== 4'b0000 ||
          bus.grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap2: got pulse %b dack %b gv %b want 0 0000 0",
                  bus.release_pulse, bus.dack, bus.grant_valid);
      end
      @(negedge CLK);
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.dack !== 4'b0001) begin
         errors++;
         $display("FAIL b2b_regrant: got gv %b dack %b want 1 0001",
                  bus.grant_valid, bus.dack);
      end
      bus.dreq = '0;
      bus.xfer_done = 1'b1;
      @(negedge CLK);
      bus.xfer_done = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      bus.dreq = '0;
      bus.sw_req = '0;
      bus.mask = '0;
      bus.priority_type = 1'b0;
      bus.dreq_sense_low = 1'b0;
      bus.dack_sense_high = 1'b1;
      bus.grant_en = 1'b0;
      bus.xfer_done = 1'b0;
      repeat (2) @(negedge CLK);
      test_reset();
      test_fixed();
      test_mask();
      test_polarity();
      test_rotating();
      test_reset_mid_grant();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending want 0",
                  exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dma_channel_arbiter.md
DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA channels (legal 2..8).
REQ-002 SHALL have parameter CH_W, default $clog2(NUM_CH), channel index width.
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port DREQ  in  NUM_CH  hardware channel requests.
REQ-006 SHALL have port SW_REQ  in  NUM_CH  software request bits; active high.
REQ-007 SHALL have port MASK  in  NUM_CH  1 = channel excluded from arbitration.
REQ-008 SHALL have port PRIORITY_TYPE  in  1  0 = fixed, 1 = rotating.
REQ-009 SHALL have port DREQ_SENSE_LOW  in  1  1 = DREQ active low.
REQ-010 SHALL have port DACK_SENSE_HIGH  in  1  1 = DACK active high.
REQ-011 SHALL have port GRANT_EN  in  1  timing control permits a new grant.
REQ-012 SHALL have port XFER_DONE  in  1  granted service complete (TC/EOP).
REQ-013 SHALL have port DACK  out  NUM_CH  one-hot acknowledge, polarity per DACK_SENSE_HIGH.
REQ-014 SHALL have port GRANT_VALID  out  1  a channel is granted.
REQ-015 SHALL have port GRANT_CH  out  CH_W  index of granted channel.
REQ-016 SHALL have port RELEASE_PULSE  out  1  one-cycle pulse after service ends.

Function
REQ-017 SHALL form eligible[i] = ((DREQ[i] XOR DREQ_SENSE_LOW) OR SW_REQ[i]) AND NOT MASK[i].
REQ-018 SHALL implement states ARB_IDLE, ARB_GRANT, ARB_RELEASE.
REQ-019 ARB_IDLE -> ARB_GRANT on edge where GRANT_EN=1 and any eligible bit set; winner latched that edge.
REQ-020 DACK/GRANT_VALID/GRANT_CH SHALL assert in the cycle after the sampling edge (1-cycle latency), driven from registers.
REQ-021 ARB_GRANT SHALL hold winner unchanged until XFER_DONE sampled 1; DREQ drop, MASK change or higher-priority request mid-grant SHALL be ignored.
REQ-022 ARB_GRANT -> ARB_RELEASE on XFER_DONE=1; in ARB_RELEASE DACK inactive, GRANT_VALID=0, RELEASE_PULSE=1 for exactly one cycle.
REQ-023 ARB_RELEASE -> ARB_IDLE unconditionally; no grant in ARB_RELEASE, so consecutive grants are separated by >=2 inactive DACK cycles.
REQ-024 Fixed mode: channel 0 highest, NUM_CH-1 lowest.
REQ-025 Rotating mode: highest priority = ptr, descending (ptr+1 mod NUM_CH, ...); on ARB_GRANT->ARB_RELEASE ptr <= (granted channel + 1) mod NUM_CH.
REQ-026 ptr SHALL wrap from NUM_CH-1 to 0; ptr SHALL be forced to 0 on every edge where PRIORITY_TYPE=0.
REQ-027 PRIORITY_TYPE change SHALL take effect only at the next ARB_IDLE arbitration.
REQ-028 DACK SHALL equal the internal one-hot grant vector when DACK_SENSE_HIGH=1, its bitwise inverse when 0 (combinational polarity only).
REQ-029 GRANT_EN=0 in ARB_IDLE SHALL block granting regardless of requests; GRANT_EN SHALL be ignored in other states.
REQ-030 XFER_DONE in ARB_IDLE or ARB_RELEASE SHALL be ignored.

Reset
REQ-031 RESET_N=0 SHALL immediately (asynchronously) force state=ARB_IDLE, grant vector=0, GRANT_CH=0, GRANT_VALID=0, RELEASE_PULSE=0, ptr=0.
REQ-032 Reset during ARB_GRANT SHALL drop DACK to inactive level without RELEASE_PULSE.
REQ-033 First grant after RESET_N deasserts SHALL require a full sampling edge (no grant on the deassertion edge's preceding state).

Structure
REQ-034 Package dma_arb_pkg SHALL hold arb_state_t enum and MAX_CH=8 constant.
REQ-035 Sub-module dma_rr_select SHALL be the combinational picker: inputs eligible vector and ptr, outputs one-hot winner and index; fixed mode uses ptr=0.
REQ-036 All state SHALL reside in dma_channel_arbiter; dma_rr_select SHALL be purely combinational.

Verification
REQ-037 Fixed, DREQ=4'b1010, GRANT_EN=1 -> DACK=4'b0010 next cycle, GRANT_CH=1; held until XFER_DONE.
REQ-038 Rotating, DREQ=4'b1111, four grant/done cycles -> grant order 0,1,2,3 then 0; ptr wraps 3->0.
REQ-039 MASK=4'b0001, SW_REQ=4'b0001, DREQ=0 -> no grant; clear MASK -> DACK=4'b0001 one cycle later.
REQ-040 DREQ_SENSE_LOW=1, DACK_SENSE_HIGH=0, DREQ=4'b1011 -> DACK=4'b1011 (channel 2 granted, active low).
REQ-041 RESET_N low mid-grant with DACK=4'b0100 -> DACK=0 immediately, no RELEASE_PULSE, ptr=0.
REQ-042 XFER_DONE with DREQ=4'b0011 held -> RELEASE_PULSE one cycle, DACK inactive 2 cycles, then next grant per priority.
